// File: rtl/led_blink_arbiter_pkg.sv
// Shared definitions for the LED blink arbiter: clock default, requester count
// and the service state encoding.
package led_blink_arbiter_pkg;

   localparam int CLK_HZ_DEFAULT = 16368000;
   localparam int N_REQ          = 4;
   localparam int REQ_W          = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      GAP  = 2'd3
   } state_e;

endpackage

// File: rtl/led_blink_arbiter_tick_gen.sv
// Timebase prescaler: counts 0..DIV-1 and pulses tick_o for one cycle on the
// wrap count. clr_i restarts the count so the next tick is exactly DIV cycles away.
module led_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk_diff_to_single,
   input  logic rst_n,
   input  logic clr_i,
   output logic tick_o
);

   localparam int             CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_diff_to_single or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that grants one requester at a time and blinks the LED
// blink_n times (ON/OFF pairs) followed by a dark GAP before releasing the grant.
module led_blink_arbiter
   import led_blink_arbiter_pkg::*;
#(
   parameter int CLK_HZ  = CLK_HZ_DEFAULT,
   parameter int TICK_HZ = 1000,
   parameter int ON_MS   = 250,
   parameter int OFF_MS  = 250,
   parameter int GAP_MS  = 1000
) (
   input  logic                 clk_diff_to_single,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [4*N_REQ-1:0]   blink_n,
   output logic [N_REQ-1:0]     gnt,
   output logic                 busy,
   output logic                 done,
   output logic [REQ_W-1:0]     done_id,
   output logic                 led_h
);

   localparam int DIV    = CLK_HZ / TICK_HZ;
   localparam int PH_MAX = (ON_MS > OFF_MS) ? ((ON_MS > GAP_MS) ? ON_MS : GAP_MS)
                                            : ((OFF_MS > GAP_MS) ? OFF_MS : GAP_MS);
   localparam int PH_W   = $clog2(PH_MAX) + 1;

   localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_MS - 1);
   localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_MS - 1);
   localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_MS - 1);

   // Reset asserts asynchronously but is released only after two clock edges.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk_diff_to_single or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   state_e              state_q;
   logic [N_REQ-1:0]    gnt_q;
   logic                busy_q;
   logic                led_q;
   logic [REQ_W-1:0]    ptr_q;
   logic [REQ_W-1:0]    winner_q;
   logic [3:0]          rem_q;
   logic [PH_W-1:0]     phase_q;

   logic [3:0]          blink_arr [N_REQ];
   logic                win_found;
   logic [REQ_W-1:0]    win_idx;
   logic [REQ_W-1:0]    cand;
   logic                tick;
   logic                grant;
   logic                phase_end;
   logic [PH_W-1:0]     phase_last;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_blink
         assign blink_arr[gi] = blink_n[4*gi +: 4];
      end
   endgenerate

   // Search starts one past the last winner, so the pointer alone breaks ties.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ptr_q + REQ_W'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign grant = (state_q == IDLE) && win_found;

   led_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk_diff_to_single (clk_diff_to_single),
      .rst_n              (rst_int_n),
      .clr_i              (grant),
      .tick_o             (tick)
   );

   always_comb begin
      phase_last = ON_LAST;
      case (state_q)
         OFF:     phase_last = OFF_LAST;
         GAP:     phase_last = GAP_LAST;
         default: phase_last = ON_LAST;
      endcase
   end

   assign phase_end = tick && (phase_q == phase_last);

   always_ff @(posedge clk_diff_to_single or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         busy_q   <= 1'b0;
         led_q    <= 1'b0;
         ptr_q    <= REQ_W'(N_REQ - 1);
         winner_q <= '0;
         rem_q    <= '0;
         phase_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  state_q  <= ON;
                  gnt_q    <= N_REQ'(1) << win_idx;
                  busy_q   <= 1'b1;
                  led_q    <= 1'b1;
                  ptr_q    <= win_idx;
                  winner_q <= win_idx;
                  rem_q    <= (blink_arr[win_idx] == 4'd0) ? 4'd1 : blink_arr[win_idx];
                  phase_q  <= '0;
               end
            end
            ON: begin
               if (phase_end) begin
                  state_q <= OFF;
                  led_q   <= 1'b0;
                  phase_q <= '0;
               end else if (tick) begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            OFF: begin
               if (phase_end) begin
                  phase_q <= '0;
                  if (rem_q > 4'd1) begin
                     rem_q   <= rem_q - 4'd1;
                     state_q <= ON;
                     led_q   <= 1'b1;
                  end else begin
                     state_q <= GAP;
                  end
               end else if (tick) begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            GAP: begin
               if (phase_end) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  phase_q <= '0;
               end else if (tick) begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign led_h   = led_q;
   assign done    = (state_q == GAP) && phase_end;
   assign done_id = done ? winner_q : '0;

endmodule
